// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, types and fetch packet for the 16-bit CPU.
package cpu_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int OPC_W  = 4;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] instr_t;
    typedef logic [OPC_W-1:0]  opcode_t;
    localparam opcode_t HALT_OPC = 4'hF;
    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fetch_pkt_t;
    typedef enum logic {RUN, HALTED} fetch_state_t;
    function automatic opcode_t opcode_of(instr_t i);
        return i[DATA_W-1 -: OPC_W];
    endfunction
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: 2-entry FIFO of fetch packets with push/pop/flush.
module fetch_skid_buffer
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  fetch_pkt_t i_pkt,
    input  logic       i_pop,
    input  logic       i_flush,
    output fetch_pkt_t o_head,
    output logic [1:0] o_count,
    output logic       o_full,
    output logic       o_empty
);
    fetch_pkt_t r_mem [2];
    logic       r_rd, r_wr;
    logic [1:0] r_count;
    logic       w_pop, w_push;

    assign o_empty = (r_count == 2'd0);
    assign o_full  = (r_count == 2'd2);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];
    assign w_pop   = i_pop & ~o_empty;
    // when full, a push only lands if the head leaves in the same cycle
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) r_mem[r_wr] <= i_pkt;
            if (w_push) r_wr <= ~r_wr;
            if (w_pop) r_rd <= ~r_rd;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, ROM issue and redirect handling for the fetch stage.
// Optional HALT detection when FETCH_HALT_EN is defined.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter addr_t RESET_PC = '0
)(
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_q,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic              halted
);
    logic [ADDR_W-1:0] r_pc, r_inflight_pc;
    logic              r_inflight;
    logic              w_pop, w_push, w_issue, w_halt_push, w_halted, w_full, w_empty;
    logic [1:0]        w_count;
    fetch_pkt_t        w_head;

    fetch_skid_buffer u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pkt   ({r_inflight_pc, rom_q}),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rom_address = r_pc;
    assign out_valid   = ~w_empty;
    assign out_pc      = w_head.pc;
    assign out_instr   = w_head.instr;
    assign halted      = w_halted;
    assign w_pop       = ~w_empty & out_ready;
    assign w_push      = r_inflight & ~redirect_valid;
    // reserve a slot for every word in flight so nothing is ever dropped
    assign w_issue     = ~redirect_valid & ~w_halted & ~w_halt_push & ~(w_full & ~w_pop)
                       & (({1'b0, w_count} + {2'b0, r_inflight}) <= ({2'b0, w_pop} + 3'd1));

`ifdef FETCH_HALT_EN
    fetch_state_t r_state, w_state_nx;

    assign w_halt_push = w_push & (r_state == RUN) & (opcode_of(rom_q) == HALT_OPC);
    assign w_halted    = (r_state == HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RUN;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = redirect_valid ? RUN : (w_halt_push ? HALTED : r_state);
    end
`else
    assign w_halt_push = 1'b0;
    assign w_halted    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) r_inflight_pc <= r_pc;
            if (redirect_valid) r_pc <= redirect_pc;
            else if (w_issue)   r_pc <= r_pc + 1'b1;
        end
    end
endmodule
